// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated reps times with GAP idle cycles between.
// Optional parity bit after each repetition when SEQ_GEN_PARITY_EN is defined.
module seq_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int REP_BITS = PAT_W + 1;
`else
  localparam int REP_BITS = PAT_W;
`endif
  localparam int BCW = $clog2(REP_BITS + 1);
  localparam int GCW = $clog2(GAP + 2);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             reload;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q, par_d;
`endif

  // Outputs are computed for the coming cycle, so bit_cnt_q counts bits already on the line.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    dout_d    = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    reload    = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (reps != '0) begin
            pat_d     = pattern;
            rep_cnt_d = reps;
            reload    = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
            par_d     = ^pattern;
`endif
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (bit_cnt_q != BCW'(REP_BITS)) begin
          dout_d    = shreg_q[PAT_W-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          shreg_d   = {shreg_q[PAT_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BCW'(1);
`ifdef SEQ_GEN_PARITY_EN
          if (bit_cnt_q == BCW'(PAT_W)) dout_d = par_q;
`endif
        end else begin
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
          if (rep_cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GCW'(1);
            busy_d    = 1'b1;
          end else begin
            reload = 1'b1;
          end
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == GCW'(GAP)) reload = 1'b1;
        else gap_cnt_d = gap_cnt_q + GCW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (reload) begin
      state_d   = S_SEND;
      dout_d    = pat_d[PAT_W-1];
      shreg_d   = {pat_d[PAT_W-2:0], 1'b0};
      bit_cnt_d = BCW'(1);
      valid_d   = 1'b1;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      dout_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: GAP=2 and GAP=0 instances driven in parallel, checked against a job-level expected-output queue.
module tb_seq_gen;
  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic dout2, valid2, busy2, done2;
  logic dout0, valid0, busy0, done0;

  always #5 clk = ~clk;

  seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(2)) u_dut_gap2 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .dout(dout2), .valid(valid2), .busy(busy2), .done(done2)
  );

  seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(0)) u_dut_gap0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .dout(dout0), .valid(valid0), .busy(busy0), .done(done0)
  );

  // Each element is one cycle of {done, busy, valid, dout}.
  typedef logic [3:0] q_t[$];
  q_t q2, q0;
  logic [3:0] exp2, exp0;
  int checks_q = 0;
  int failures_q = 0;

  function automatic q_t build_job(input int gap, input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] n);
    q_t q;
    int nn;
    nn = int'(n);
    for (int r = 0; r < nn; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) q.push_back({3'b011, pat[b]});
`ifdef SEQ_GEN_PARITY_EN
      q.push_back({3'b011, ^pat});
`endif
      if (r < nn - 1)
        for (int g = 0; g < gap; g++) q.push_back(4'b0100);
    end
    q.push_back(4'b1000);
    return q;
  endfunction

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks_q++;
    if (got !== exp) begin
      failures_q++;
      $display("FAIL %s t=%0t got {done,busy,valid,dout}=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model by the job rules, compare both DUTs.
  task automatic cyc(input logic r, input logic s, input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] n);
    rst = r; start = s; pattern = p; reps = n;
    @(posedge clk);
    #1;
    if (!r) begin
      q2.delete(); q0.delete();
      exp2 = 4'b0000; exp0 = 4'b0000;
    end else begin
      if (s && !exp2[2]) begin
        q2 = build_job(2, p, n);
        $display("job gap2 t=%0t pattern=%b reps=%0d cycles=%0d", $time, p, n, q2.size());
      end
      if (s && !exp0[2]) begin
        q0 = build_job(0, p, n);
        $display("job gap0 t=%0t pattern=%b reps=%0d cycles=%0d", $time, p, n, q0.size());
      end
      if (q2.size() > 0) exp2 = q2.pop_front(); else exp2 = 4'b0000;
      if (q0.size() > 0) exp0 = q0.pop_front(); else exp0 = 4'b0000;
    end
    check_val("gap2", {done2, busy2, valid2, dout2}, exp2);
    check_val("gap0", {done0, busy0, valid0, dout0}, exp0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'b0000, 4'd0);
  endtask

  initial begin
    exp2 = 4'b0000; exp0 = 4'b0000;
    cyc(1'b0, 1'b0, 4'b0000, 4'd0);
    cyc(1'b0, 1'b1, 4'b1111, 4'd3);
    // Basic job
    cyc(1'b1, 1'b1, 4'b1101, 4'd2);
    idle(12);
    // reps = 0
    cyc(1'b1, 1'b1, 4'b1111, 4'd0);
    idle(3);
    // Alternating pattern, three repetitions
    cyc(1'b1, 1'b1, 4'b1010, 4'd3);
    idle(16);
    // Ignored start mid-job, then a start on the done cycle
    cyc(1'b1, 1'b1, 4'b1101, 4'd2);
    cyc(1'b1, 1'b0, 4'b1101, 4'd2);
    cyc(1'b1, 1'b1, 4'b0000, 4'd5);
    idle(8);
    cyc(1'b1, 1'b1, 4'b0110, 4'd1);
    idle(14);
    // Reset mid-job, then a fresh job
    cyc(1'b1, 1'b1, 4'b1101, 4'd2);
    idle(2);
    cyc(1'b0, 1'b0, 4'b1101, 4'd2);
    idle(12);
    cyc(1'b1, 1'b1, 4'b1011, 4'd2);
    idle(14);
    // Maximum repetition count
    cyc(1'b1, 1'b1, 4'b1001, 4'd15);
    idle(100);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s;
      logic [PAT_W-1:0] p;
      logic [CNT_W-1:0] n;
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 2) == 0);
      p = PAT_W'($urandom);
      n = ($urandom_range(0, 19) == 0) ? CNT_W'(15) : CNT_W'($urandom_range(0, 5));
      cyc(r, s, p, n);
    end
    idle(120);
    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end
endmodule
